// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake bundle between fetch, the decode stage and execute.
//   master : driven by the environment (fetch side inputs, downstream ready, flush)
//   slave  : the decode stage itself
// Signals:
//   flush                         discard everything buffered in the stage
//   in_valid/in_ready             upstream handshake, in_instr/in_pc payload
//   out_valid/out_ready           downstream handshake
//   out_pc .. out_illegal         decoded head-of-FIFO bundle
`timescale 1ns/1ps
interface decode_stage_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [3:0]      out_alufunc;
    logic            out_word;
    logic            out_srcb_imm;
    logic            out_regwrite;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_alufunc, out_word,
               out_srcb_imm, out_regwrite, out_rs1, out_rs2, out_rd, out_imm,
               out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_alufunc, out_word,
               out_srcb_imm, out_regwrite, out_rs1, out_rs2, out_rd, out_imm,
               out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V integer-ALU decode stage between fetch and execute.
// Decodes OP-IMM, OP, LUI and (XLEN=64 with ENABLE_WORD) OP-IMM-32/OP-32 combinationally
// from the incoming instruction and buffers the decoded bundle in a small skid FIFO.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    decode_stage_if.slave (flush, in_* handshake, out_* decoded head entry)
// Parameters:
//   XLEN        32 or 64, width of PC and immediate
//   ENABLE_WORD decode the *W forms (ignored when XLEN=32)
//   BUF_DEPTH   FIFO entries, 1..4
`timescale 1ns/1ps
module decode_stage #(
    parameter int XLEN        = 64,
    parameter int ENABLE_WORD = 1,
    parameter int BUF_DEPTH   = 2
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);

    localparam bit WORD_EN = (ENABLE_WORD != 0) && (XLEN == 64);
    localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [3:0]      alufunc;
        logic            word;
        logic            srcb_imm;
        logic            regwrite;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_w;
    logic            shamt_ok;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    // Shift immediates carry only the shift amount, never the funct bits above it.
    assign imm_sh = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
    assign imm_w  = XLEN'(instr[24:20]);
    // On RV32 a shift amount of 32 or more is not encodable.
    assign shamt_ok = (XLEN == 64) ? 1'b1 : ~instr[25];

    logic            dec_legal;
    logic [3:0]      dec_alu;
    logic            dec_word;
    logic            dec_srcb;
    logic [XLEN-1:0] dec_imm_raw;
    entry_t          dec;

    always_comb begin
        dec_legal   = 1'b0;
        dec_alu     = ALU_ADD;
        dec_word    = 1'b0;
        dec_srcb    = 1'b0;
        dec_imm_raw = '0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_srcb    = 1'b1;
                dec_imm_raw = imm_i;
                dec_legal   = 1'b1;
                case (f3)
                    3'd0: dec_alu = ALU_ADD;
                    3'd2: dec_alu = ALU_SLT;
                    3'd3: dec_alu = ALU_SLTU;
                    3'd4: dec_alu = ALU_XOR;
                    3'd6: dec_alu = ALU_OR;
                    3'd7: dec_alu = ALU_AND;
                    3'd1: begin
                        dec_alu     = ALU_SLL;
                        dec_imm_raw = imm_sh;
                        dec_legal   = (instr[31:26] == 6'd0) && shamt_ok;
                    end
                    default: begin // f3 = 5
                        dec_alu     = instr[30] ? ALU_SRA : ALU_SRL;
                        dec_imm_raw = imm_sh;
                        dec_legal   = !instr[31] && (instr[29:26] == 4'd0) && shamt_ok;
                    end
                endcase
            end
            OPC_OP: begin
                if (f7 == F7_ZERO) begin
                    dec_legal = 1'b1;
                    case (f3)
                        3'd0:    dec_alu = ALU_ADD;
                        3'd1:    dec_alu = ALU_SLL;
                        3'd2:    dec_alu = ALU_SLT;
                        3'd3:    dec_alu = ALU_SLTU;
                        3'd4:    dec_alu = ALU_XOR;
                        3'd5:    dec_alu = ALU_SRL;
                        3'd6:    dec_alu = ALU_OR;
                        default: dec_alu = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'd0) begin
                        dec_alu   = ALU_SUB;
                        dec_legal = 1'b1;
                    end else if (f3 == 3'd5) begin
                        dec_alu   = ALU_SRA;
                        dec_legal = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec_alu     = ALU_PASSB;
                dec_imm_raw = imm_u;
                dec_srcb    = 1'b1;
                dec_legal   = 1'b1;
            end
            OPC_OP_IMM_32: begin
                if (WORD_EN) begin
                    dec_word = 1'b1;
                    dec_srcb = 1'b1;
                    if (f3 == 3'd0) begin
                        dec_alu     = ALU_ADD;
                        dec_imm_raw = imm_i;
                        dec_legal   = 1'b1;
                    end else if (f3 == 3'd1 && f7 == F7_ZERO) begin
                        dec_alu     = ALU_SLL;
                        dec_imm_raw = imm_w;
                        dec_legal   = 1'b1;
                    end else if (f3 == 3'd5 && (f7 == F7_ZERO || f7 == F7_ALT)) begin
                        dec_alu     = instr[30] ? ALU_SRA : ALU_SRL;
                        dec_imm_raw = imm_w;
                        dec_legal   = 1'b1;
                    end
                end
            end
            OPC_OP_32: begin
                if (WORD_EN) begin
                    dec_word = 1'b1;
                    if (f7 == F7_ZERO) begin
                        if (f3 == 3'd0) begin
                            dec_alu   = ALU_ADD;
                            dec_legal = 1'b1;
                        end else if (f3 == 3'd1) begin
                            dec_alu   = ALU_SLL;
                            dec_legal = 1'b1;
                        end else if (f3 == 3'd5) begin
                            dec_alu   = ALU_SRL;
                            dec_legal = 1'b1;
                        end
                    end else if (f7 == F7_ALT) begin
                        if (f3 == 3'd0) begin
                            dec_alu   = ALU_SUB;
                            dec_legal = 1'b1;
                        end else if (f3 == 3'd5) begin
                            dec_alu   = ALU_SRA;
                            dec_legal = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Illegal instructions travel on with all control fields neutralised
        // but their raw register fields intact for the trap handler.
        dec.pc       = bus.in_pc;
        dec.instr    = instr;
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rd       = instr[11:7];
        dec.illegal  = ~dec_legal;
        dec.regwrite = dec_legal && (instr[11:7] != 5'd0);
        dec.alufunc  = dec_legal ? dec_alu : 4'd0;
        dec.word     = dec_legal & dec_word;
        dec.srcb_imm = dec_legal & dec_srcb;
        dec.imm      = dec_legal ? dec_imm_raw : '0;
    end

    // ------------------------------------------------------------------
    // Skid FIFO
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    entry_t           mem [BUF_DEPTH];
    entry_t           head;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    // in_ready depends only on the count, so a full FIFO stays closed even
    // when the head is being consumed in the same cycle.
    assign in_ready  = (count_reg < CNT_W'(BUF_DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = bus.in_valid & in_ready & ~bus.flush;
    assign pop       = out_valid & bus.out_ready & ~bus.flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Explicit wrap keeps non-power-of-two depths correct.
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (bus.flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Storage is cleared on reset so the head reads as all-zero afterwards.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= dec;
                end
            end
        end
    endgenerate

    assign head = mem[rd_ptr_reg];

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_pc       = head.pc;
    assign bus.out_instr    = head.instr;
    assign bus.out_alufunc  = head.alufunc;
    assign bus.out_word     = head.word;
    assign bus.out_srcb_imm = head.srcb_imm;
    assign bus.out_regwrite = head.regwrite;
    assign bus.out_rs1      = head.rs1;
    assign bus.out_rs2      = head.rs2;
    assign bus.out_rd       = head.rd;
    assign bus.out_imm      = head.imm;
    assign bus.out_illegal  = head.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV decode stage sitting between fetch and execute.
- Accepts raw 32-bit instructions with their PC over a valid/ready handshake and decodes every integer ALU class: OP-IMM, OP, LUI and, optionally, the RV64 word forms.
- Decoded bundles are buffered in a small skid FIFO, so a back-pressure stall never drops or duplicates an instruction.
- Generalises the single-op combinational decoder in width, op coverage and buffering.

Parameters:
- XLEN, 64, datapath width for PC and immediate; legal values 32 or 64.
- ENABLE_WORD, 1, decode OP-IMM-32/OP-32 (*W ops); forced off when XLEN=32.
- BUF_DEPTH, 2, skid FIFO entries; legal values 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all buffered entries; input is ignored this cycle
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- out_pc  out  XLEN  PC of head
- out_instr  out  32  raw instruction of head
- out_alufunc  out  4  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 PASSB=10
- out_word  out  1  32-bit op; execute sign-extends bit 31 of the result
- out_srcb_imm  out  1  operand B is out_imm rather than rs2
- out_regwrite  out  1  write rd
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  unsupported or ill-formed instruction

Behaviour:
- Reset:
  - FIFO count=0, pointers=0.
  - out_valid=0 and every out_* field is 0.
  - in_ready=1 in the first cycle after reset deasserts.
- Decode is combinational on in_*. The result is written into the FIFO tail when in_valid & in_ready & ~flush.
- Latency: an accepted instruction appears on out_* in the next cycle at the earliest.
- in_ready = (count < BUF_DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
- Pop when out_valid & out_ready.
  - Push and pop in the same cycle: count is unchanged.
  - A pop in the same cycle does not make room for a push when count==BUF_DEPTH.
- out_* fields always reflect the head entry. When out_valid=0 they hold the last head value, which is don't-care, except after reset, where they are 0.
- Pointers wrap modulo BUF_DEPTH. Non-power-of-two depths must wrap correctly.
- flush: count:=0 and out_valid:=0 next cycle. flush wins over push and pop.
- Decode rules, on opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]:
  - OP-IMM (0010011):
    - f3 0/2/3/4/6/7 map to ADD/SLT/SLTU/XOR/OR/AND.
    - imm = sext(instr[31:20]); srcb_imm=1.
    - f3=1 is SLL; f3=5 is SRL when instr[30]=0 and SRA when instr[30]=1.
    - Shift amount is instr[25:20] for XLEN=64, instr[24:20] for XLEN=32.
    - Shifts are illegal if the remaining upper funct bits are nonzero, or, for XLEN=32, if instr[25]=1.
  - OP (0110011):
    - f7=0000000 maps f3 0..7 to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
    - f7=0100000 with f3=0 is SUB; with f3=5 is SRA.
    - Any other f7 is illegal. srcb_imm=0.
  - LUI (0110111): alufunc=PASSB, imm = sext({instr[31:12],12'b0}), srcb_imm=1.
  - OP-IMM-32 (0011011) and OP-32 (0111011), only when ENABLE_WORD and XLEN=64:
    - ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW, with out_word=1.
    - Word shifts with instr[25]=1 are illegal.
- out_regwrite = legal & (rd != 0).
- Illegal instruction:
  - illegal=1, regwrite=0, alufunc=0, word=0, imm=0, srcb_imm=0.
  - pc, instr, rs1, rs2 and rd still carry their raw field values.
  - The instruction is still buffered and handed on, not dropped.
- Reset asserted mid-stream: all entries are lost and the reset values apply on the next edge.

Test Plan:
- ADDI: addi x1,x0,5 (0x00500093) at pc 0x80000000 -> next cycle out_valid=1, alufunc=0, imm=5, rd=1, rs1=0, srcb_imm=1, regwrite=1, illegal=0.
- SUB: sub x3,x1,x2 (0x402081B3) -> alufunc=1, rs1=1, rs2=2, rd=3, srcb_imm=0; srai x4,x4,3 (0x40325213) -> alufunc=7, imm=3.
- LUI and writes to x0:
  - lui x5,0x12345 (0x123452B7) -> alufunc=10, imm=0x0000000012345000.
  - addi x0,x0,0 (0x00000013) -> regwrite=0, illegal=0.
- Word forms:
  - addiw x6,x1,-1 (0xFFF0831B) with ENABLE_WORD=1 -> word=1, imm=0xFFFFFFFFFFFFFFFF.
  - Same instruction with ENABLE_WORD=0 -> illegal=1, regwrite=0.
- Back-pressure, BUF_DEPTH=2:
  - Hold out_ready=0 and push 3 instructions -> in_ready drops after 2 are accepted; the third is held upstream.
  - Release out_ready -> output order is 1,2,3 with none lost or duplicated.
  - Random valid/ready over 1000 instructions -> the output stream equals the input stream.
- Flush and reset:
  - Flush with 2 buffered entries while pushing a 3rd -> next cycle out_valid=0, count=0, and the 3rd is not captured.
  - Reset mid-stream -> all outputs 0 and in_ready=1 after the reset edge.
